// File: rtl/rc4_engine.sv
// rtl/rc4_engine.sv - RC4 engine: S-box init, key scheduling and keystream XOR decryption
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   decrypt_en,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_we,
  input  logic [7:0]             s_rdata,
  output logic [MSG_AW-1:0]      m_addr,
  input  logic [7:0]             m_rdata,
  output logic [MSG_AW-1:0]      d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_we,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             state_tap
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]     KIDX_LAST = KW'(KEY_BYTES - 1);
  localparam logic [MSG_AW-1:0] K_LAST    = MSG_AW'(MSG_LEN - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_KSA  = 3'd2;
  localparam logic [2:0] ST_PRGA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Per-byte step phases; KSA uses the first six, PRGA all nine.
  localparam logic [3:0] PH_RD_I   = 4'd0;
  localparam logic [3:0] PH_WAIT_I = 4'd1;
  localparam logic [3:0] PH_RD_J   = 4'd2;
  localparam logic [3:0] PH_WAIT_J = 4'd3;
  localparam logic [3:0] PH_WR_I   = 4'd4;
  localparam logic [3:0] PH_WR_J   = 4'd5;
  localparam logic [3:0] PH_RD_F   = 4'd6;
  localparam logic [3:0] PH_WAIT_F = 4'd7;
  localparam logic [3:0] PH_WR_D   = 4'd8;

  logic [2:0]        state;
  logic [3:0]        phase;
  logic [7:0]        i, j, si, sj;
  logic [KW-1:0]     kidx;
  logic [MSG_AW-1:0] k;
  logic              dec_en;
  logic [7:0]        key_byte;
  logic [7:0]        j_ksa;

  // Select key byte kidx; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = key[7:0];
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) key_byte = key[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

  // KSA j update uses s[i] straight off the RAM; the result only feeds registers.
  assign j_ksa = j + s_rdata + key_byte;

  assign busy      = (state == ST_INIT) || (state == ST_KSA) || (state == ST_PRGA);
  assign done      = (state == ST_DONE);
  assign state_tap = state;

  // Top FSM and step sequencer; every RAM/ROM port output is a register loaded one edge ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= PH_RD_I;
      i       <= 8'd0;
      j       <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      kidx    <= '0;
      k       <= '0;
      dec_en  <= 1'b0;
      s_addr  <= 8'd0;
      s_wdata <= 8'd0;
      s_we    <= 1'b0;
      m_addr  <= '0;
      d_addr  <= '0;
      d_wdata <= 8'd0;
      d_we    <= 1'b0;
    end else begin
      s_we <= 1'b0;
      d_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dec_en  <= decrypt_en;
            state   <= ST_INIT;
            i       <= 8'd0;
            s_addr  <= 8'd0;
            s_wdata <= 8'd0;
            s_we    <= 1'b1;
          end
        end
        ST_INIT: begin
          if (i == 8'hff) begin
            state  <= ST_KSA;
            phase  <= PH_RD_I;
            i      <= 8'd0;
            j      <= 8'd0;
            kidx   <= '0;
            s_addr <= 8'd0;
          end else begin
            i       <= i + 8'd1;
            s_addr  <= i + 8'd1;
            s_wdata <= i + 8'd1;
            s_we    <= 1'b1;
          end
        end
        ST_KSA: begin
          case (phase)
            PH_RD_I:   phase <= PH_WAIT_I;
            PH_WAIT_I: begin
              si     <= s_rdata;
              j      <= j_ksa;
              s_addr <= j_ksa;
              phase  <= PH_RD_J;
            end
            PH_RD_J:   phase <= PH_WAIT_J;
            PH_WAIT_J: begin
              sj      <= s_rdata;
              s_addr  <= i;
              s_wdata <= s_rdata;
              s_we    <= 1'b1;
              phase   <= PH_WR_I;
            end
            PH_WR_I: begin
              s_addr  <= j;
              s_wdata <= si;
              s_we    <= 1'b1;
              phase   <= PH_WR_J;
            end
            PH_WR_J: begin
              kidx  <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
              phase <= PH_RD_I;
              if (i == 8'hff) begin
                if (dec_en) begin
                  // PRGA pre-increments i, so its first read is s[1].
                  state  <= ST_PRGA;
                  i      <= 8'd1;
                  j      <= 8'd0;
                  k      <= '0;
                  s_addr <= 8'd1;
                end else begin
                  state <= ST_DONE;
                end
              end else begin
                i      <= i + 8'd1;
                s_addr <= i + 8'd1;
              end
            end
            default: phase <= PH_RD_I;
          endcase
        end
        ST_PRGA: begin
          case (phase)
            PH_RD_I:   phase <= PH_WAIT_I;
            PH_WAIT_I: begin
              si     <= s_rdata;
              j      <= j + s_rdata;
              s_addr <= j + s_rdata;
              phase  <= PH_RD_J;
            end
            PH_RD_J:   phase <= PH_WAIT_J;
            PH_WAIT_J: begin
              sj      <= s_rdata;
              s_addr  <= i;
              s_wdata <= s_rdata;
              s_we    <= 1'b1;
              phase   <= PH_WR_I;
            end
            PH_WR_I: begin
              s_addr  <= j;
              s_wdata <= si;
              s_we    <= 1'b1;
              phase   <= PH_WR_J;
            end
            PH_WR_J: begin
              s_addr <= si + sj;
              m_addr <= k;
              phase  <= PH_RD_F;
            end
            PH_RD_F:   phase <= PH_WAIT_F;
            PH_WAIT_F: begin
              d_addr  <= k;
              d_wdata <= s_rdata ^ m_rdata;
              d_we    <= 1'b1;
              phase   <= PH_WR_D;
            end
            PH_WR_D: begin
              phase <= PH_RD_I;
              if (k == K_LAST) begin
                state <= ST_DONE;
              end else begin
                k      <= k + 1'b1;
                i      <= i + 8'd1;
                s_addr <= i + 8'd1;
              end
            end
            default: phase <= PH_RD_I;
          endcase
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_engine.sv
// tb/tb_rc4_engine.sv - self-checking bench for rc4_engine against a software RC4 model
module tb_rc4_engine;

  logic clk;
  logic reset;
  logic [2:0]       start_v, dec_v, s_we_v, d_we_v, busy_v, done_v, clr_req;
  logic [2:0][47:0] key_v;
  logic [2:0][7:0]  s_addr_v, s_wdata_v, s_rdata_v, m_rdata_v, d_wdata_v, ma_v, da_v;
  logic [2:0][2:0]  state_v;
  logic [3:0] ma0, da0, ma2, da2;
  logic [2:0] ma1, da1;

  logic [7:0] smem [3][256];
  logic [7:0] rom  [3][16];
  logic [7:0] dmem [3][16];
  logic [7:0] exp_s [3][256];
  logic [7:0] exp_d [3][16];
  logic [2:0] dec_r;
  int run_cyc [3];
  int launch_cnt [3], seen_launch [3];
  int abort_cnt [3], seen_abort [3];
  int n_cmp, n_bad;
  logic mon_en;

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .decrypt_en(dec_v[0]), .key(key_v[0][23:0]),
    .s_addr(s_addr_v[0]), .s_wdata(s_wdata_v[0]), .s_we(s_we_v[0]), .s_rdata(s_rdata_v[0]),
    .m_addr(ma0), .m_rdata(m_rdata_v[0]), .d_addr(da0), .d_wdata(d_wdata_v[0]), .d_we(d_we_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .state_tap(state_v[0]));

  rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .decrypt_en(dec_v[1]), .key(key_v[1][31:0]),
    .s_addr(s_addr_v[1]), .s_wdata(s_wdata_v[1]), .s_we(s_we_v[1]), .s_rdata(s_rdata_v[1]),
    .m_addr(ma1), .m_rdata(m_rdata_v[1]), .d_addr(da1), .d_wdata(d_wdata_v[1]), .d_we(d_we_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .state_tap(state_v[1]));

  rc4_engine #(.KEY_BYTES(6), .MSG_LEN(14)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .decrypt_en(dec_v[2]), .key(key_v[2][47:0]),
    .s_addr(s_addr_v[2]), .s_wdata(s_wdata_v[2]), .s_we(s_we_v[2]), .s_rdata(s_rdata_v[2]),
    .m_addr(ma2), .m_rdata(m_rdata_v[2]), .d_addr(da2), .d_wdata(d_wdata_v[2]), .d_we(d_we_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .state_tap(state_v[2]));

  assign ma_v[0] = {4'b0, ma0};
  assign ma_v[1] = {5'b0, ma1};
  assign ma_v[2] = {4'b0, ma2};
  assign da_v[0] = {4'b0, da0};
  assign da_v[1] = {5'b0, da1};
  assign da_v[2] = {4'b0, da2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kb_of(input int n);
    return (n == 0) ? 3 : (n == 1) ? 4 : 6;
  endfunction

  function automatic int len_of(input int n);
    return (n == 0) ? 9 : (n == 1) ? 5 : 14;
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int len, input int k);
    logic [127:0] t;
    t = v >> ((len - 1 - k) * 8);
    return t[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Synchronous S-box RAM, ciphertext ROM and plaintext RAM, one set per instance.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (s_we_v[n]) smem[n][s_addr_v[n]] <= s_wdata_v[n];
      s_rdata_v[n] <= smem[n][s_addr_v[n]];
      m_rdata_v[n] <= rom[n][ma_v[n][3:0]];
      if (clr_req[n]) begin
        for (int a = 0; a < 16; a++) dmem[n][a] <= 8'h00;
      end else if (d_we_v[n]) begin
        dmem[n][da_v[n][3:0]] <= d_wdata_v[n];
      end
    end
  end

  // Textbook RC4: KSA result kept in exp_s, decrypted bytes in exp_d.
  task automatic model(input int n);
    int s [256];
    int i, j, t, kbn, kbyte;
    logic [47:0] sh;
    kbn = kb_of(n);
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      sh = key_v[n] >> ((kbn - 1 - (a % kbn)) * 8);
      kbyte = int'(sh[7:0]);
      j = (j + s[a] + kbyte) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    for (int a = 0; a < 256; a++) exp_s[n][a] = 8'(s[a]);
    i = 0;
    j = 0;
    for (int k = 0; k < len_of(n); k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_d[n][k] = rom[n][k] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  // Per-cycle checker: the spec's cycle timeline of every run against the DUT outputs.
  always @(negedge clk) begin : mon
    int c, b, ph, k;
    logic exp_swe, exp_dwe;
    logic [2:0] st;
    if (mon_en) begin
      for (int n = 0; n < 3; n++) begin
        if (abort_cnt[n] != seen_abort[n]) begin
          seen_abort[n] = abort_cnt[n];
          run_cyc[n] = -1;
        end
        if (launch_cnt[n] != seen_launch[n]) begin
          seen_launch[n] = launch_cnt[n];
          run_cyc[n] = 0;
        end
        c = run_cyc[n];
        if (c < 0) begin
          chk("idle", {busy_v[n], done_v[n], state_v[n], s_we_v[n], d_we_v[n]}, 64'd0);
        end else begin
          b = dec_r[n] ? 1792 + 9 * len_of(n) : 1792;
          ph = 0;
          k = 0;
          exp_swe = 1'b0;
          exp_dwe = 1'b0;
          if (c < 256) begin
            exp_swe = 1'b1;
            chk("init_write", {s_addr_v[n], s_wdata_v[n]}, {8'(c), 8'(c)});
          end else if (c < 1792) begin
            exp_swe = ((c - 256) % 6) >= 4;
          end else if (c < b) begin
            ph = (c - 1792) % 9;
            k = (c - 1792) / 9;
            exp_swe = (ph == 4) || (ph == 5);
            exp_dwe = (ph == 8);
            if (ph == 6) chk("m_addr", ma_v[n], 64'(k));
            if (ph == 8) begin
              chk("d_addr", da_v[n], 64'(k));
              chk("d_wdata", d_wdata_v[n], exp_d[n][k]);
            end
          end
          if (c < b) st = (c < 256) ? 3'd1 : (c < 1792) ? 3'd2 : 3'd3;
          else if (c == b) st = 3'd4;
          else st = 3'd0;
          chk("timeline", {busy_v[n], done_v[n], state_v[n]},
              {(c < b) ? 1'b1 : 1'b0, (c == b) ? 1'b1 : 1'b0, st});
          chk("s_we", s_we_v[n], exp_swe);
          chk("d_we", d_we_v[n], exp_dwe);
          run_cyc[n] = (c >= b + 1) ? -1 : c + 1;
        end
      end
    end
  end

  task automatic set_rom(input int n, input logic [127:0] ct, input int len);
    for (int k = 0; k < len; k++) rom[n][k] = byte_of(ct, len, k);
  endtask

  task automatic rand_rom(input int n);
    for (int k = 0; k < 16; k++) rom[n][k] = 8'($urandom);
  endtask

  // Call at negedge+1 in an IDLE cycle; start is sampled at the next rising edge.
  task automatic launch(input int n, input logic [47:0] kv, input bit dec, input int hold);
    key_v[n] = kv;
    dec_v[n] = dec;
    dec_r[n] = dec;
    model(n);
    clr_req[n] = 1'b1;
    start_v[n] = 1'b1;
    launch_cnt[n]++;
    @(negedge clk); #1;
    clr_req[n] = 1'b0;
    repeat (hold) begin @(negedge clk); #1; end
    start_v[n] = 1'b0;
  endtask

  task automatic wait_end(input int n);
    int cnt;
    cnt = 0;
    while (run_cyc[n] >= 0 && cnt < 5000) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk("run_bound", (cnt < 5000) ? 1 : 0, 64'd1);
  endtask

  task automatic check_plain(input int n, input logic [127:0] pt);
    for (int k = 0; k < len_of(n); k++) begin
      chk("plain", dmem[n][k], byte_of(pt, len_of(n), k));
      chk("model_pin", exp_d[n][k], byte_of(pt, len_of(n), k));
    end
  endtask

  task automatic check_dmem(input int n);
    for (int k = 0; k < len_of(n); k++) chk("dmem", dmem[n][k], exp_d[n][k]);
  endtask

  task automatic check_sbox(input int n);
    for (int a = 0; a < 256; a++) chk("sbox", smem[n][a], exp_s[n][a]);
  endtask

  initial begin
    logic [47:0] rk;
    bit rd;
    int cnt;
    n_cmp = 0;
    n_bad = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    start_v = '0;
    dec_v = '0;
    key_v = '0;
    clr_req = '0;
    dec_r = '0;
    for (int n = 0; n < 3; n++) begin
      run_cyc[n] = -1;
      launch_cnt[n] = 0;
      seen_launch[n] = 0;
      abort_cnt[n] = 0;
      seen_abort[n] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      for (int n = 0; n < 3; n++)
        chk("reset_outputs", {state_v[n], busy_v[n], done_v[n], s_we_v[n], d_we_v[n], s_addr_v[n],
                              s_wdata_v[n], ma_v[n], da_v[n], d_wdata_v[n]}, 64'd0);
    end

    set_rom(0, 128'hBBF316E8D940AF0AD3, 9);
    launch(0, 48'h4B6579, 1'b1, 0);
    wait_end(0);
    check_plain(0, "Plaintext");

    set_rom(1, 128'h1021BF0420, 5);
    launch(1, 48'h57696B69, 1'b1, 0);
    wait_end(1);
    check_plain(1, "pedia");

    set_rom(2, 128'h45A01F645FC35B383552544B9BF5, 14);
    launch(2, "Secret", 1'b1, 0);
    wait_end(2);
    check_plain(2, "Attack at dawn");

    launch(0, 48'h4B6579, 1'b0, 0);
    wait_end(0);
    check_sbox(0);

    launch(0, 48'h4B6579, 1'b1, 0);
    cnt = 0;
    while (run_cyc[0] != 1001 && cnt < 3000) begin @(negedge clk); #1; cnt++; end
    chk("reach_cycle_1000", run_cyc[0], 64'd1001);
    reset = 1'b1;
    abort_cnt[0]++;
    @(negedge clk); #1;
    chk("reset_mid", {state_v[0], busy_v[0], done_v[0]}, 64'd0);
    reset = 1'b0;
    repeat (1000) begin @(negedge clk); #1; end
    launch(0, 48'h4B6579, 1'b1, 0);
    wait_end(0);
    check_plain(0, "Plaintext");

    rand_rom(1);
    rk = {16'($urandom), 32'($urandom)};
    launch(1, rk, 1'b1, 500);
    wait_end(1);
    check_dmem(1);
    set_rom(1, 128'h1021BF0420, 5);
    launch(1, 48'h57696B69, 1'b1, 0);
    wait_end(1);
    check_plain(1, "pedia");

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 3; n++) begin
        rand_rom(n);
        rk = {16'($urandom), 32'($urandom)};
        rd = ($urandom_range(0, 3) != 0);
        launch(n, rk, rd, 0);
        wait_end(n);
        if (rd) check_dmem(n);
        else check_sbox(n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
